// File: rtl/wallace_mul_seq_pkg.sv
// Shared types and helpers for the segmented sequential multiplier controller.
//   state_e   : controller state encoding (idle / run / done)
//   DEF_SEG_W : default segment width (operand width of the shared multiplier)
//   DEF_SEGS  : default number of segments per operand
//   shift_amt : bit offset of the partial product produced on pass idx
package wallace_mul_seq_pkg;

  localparam int unsigned DEF_SEG_W = 5;
  localparam int unsigned DEF_SEGS  = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Pass idx multiplies A segment (idx % segs) by B segment (idx / segs), so its
  // partial product lands seg_w * (i + j) bits up in the full product.
  function automatic int unsigned shift_amt(input int unsigned idx,
                                            input int unsigned seg_w,
                                            input int unsigned segs);
    return seg_w * ((idx % segs) + (idx / segs));
  endfunction

endpackage

// File: rtl/wallace5x5.sv
// Unsigned 5x5 combinational multiplier built as a Wallace-style carry-save tree.
//   a, b : 5-bit unsigned operands
//   p    : 10-bit unsigned product
module wallace5x5 (
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic [9:0] p
);

  logic [9:0] pp [5];
  logic [9:0] s1, c1, s2, c2, s3, c3;

  always_comb begin
    for (int r = 0; r < 5; r++) begin
      pp[r] = {5'b0, a & {5{b[r]}}} << r;
    end
  end

  // Three carry-save layers fold five rows down to two; carries leaving bit 9
  // are always zero because the true product fits in 10 bits.
  always_comb begin
    s1 = pp[0] ^ pp[1] ^ pp[2];
    c1 = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
    s2 = s1 ^ c1 ^ pp[3];
    c2 = ((s1 & c1) | (s1 & pp[3]) | (c1 & pp[3])) << 1;
    s3 = s2 ^ c2 ^ pp[4];
    c3 = ((s2 & c2) | (s2 & pp[4]) | (c2 & pp[4])) << 1;
    p  = s3 + c3;
  end

endmodule

// File: rtl/wallace_mul_seq_ctrl.sv
// Sequencing controller: builds an OP_W x OP_W unsigned product from SEGS*SEGS passes
// through one external SEG_W x SEG_W multiplier, shift-accumulating partial products.
//   clk, rst_n               : clock, asynchronous active-low reset
//   start_valid/start_ready  : operand handshake carrying a_in, b_in
//   res_valid/res_ready      : result handshake carrying product (registered)
//   busy                     : high whenever the controller is not idle
//   mul_a, mul_b, mul_p      : segment operands to / product from the shared multiplier
module wallace_mul_seq_ctrl
  import wallace_mul_seq_pkg::*;
#(
  parameter int unsigned SEG_W = DEF_SEG_W,
  parameter int unsigned SEGS  = DEF_SEGS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [SEG_W*SEGS-1:0]   a_in,
  input  logic [SEG_W*SEGS-1:0]   b_in,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2*SEG_W*SEGS-1:0] product,
  output logic                    busy,
  output logic [SEG_W-1:0]        mul_a,
  output logic [SEG_W-1:0]        mul_b,
  input  logic [2*SEG_W-1:0]      mul_p
);

  localparam int unsigned OP_W  = SEG_W * SEGS;
  localparam int unsigned P_W   = 2 * OP_W;
  localparam int unsigned NPASS = SEGS * SEGS;
  localparam int unsigned IDX_W = (NPASS > 1) ? $clog2(NPASS) : 1;

  state_e           state_q, state_d;
  logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [P_W-1:0]   product_q, product_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  int unsigned      seg_i, seg_j;
  logic [SEG_W-1:0] a_seg, b_seg;
  logic [P_W-1:0]   term;
  logic             last_pass;

  // Segment selection: i is the inner (A) index, j the outer (B) index.
  always_comb begin
    seg_i     = 32'(idx_q) % SEGS;
    seg_j     = 32'(idx_q) / SEGS;
    a_seg     = SEG_W'(a_q >> (SEG_W * seg_i));
    b_seg     = SEG_W'(b_q >> (SEG_W * seg_j));
    term      = P_W'(mul_p) << shift_amt(32'(idx_q), SEG_W, SEGS);
    last_pass = (32'(idx_q) == NPASS - 1);
  end

  // The shared multiplier only sees real operands while passes are running.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state_q == StRun) begin
      mul_a = a_seg;
      mul_b = b_seg;
    end
  end

  assign start_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign res_valid   = (state_q == StDone);
  assign product     = product_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_q + term;
        idx_d = idx_q + 1'b1;
        if (last_pass) begin
          product_d = acc_q + term;
          idx_d     = '0;
          state_d   = StDone;
        end
      end
      StDone: begin
        // start_valid is deliberately ignored here; a new operand waits for IDLE.
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_wallace_mul_seq_ctrl.sv
// Self-checking bench for wallace_mul_seq_ctrl driving the shared wallace5x5.
module tb_wallace_mul_seq_ctrl;

  localparam int SEG_W = 5;
  localparam int SEGS  = 2;
  localparam int OP_W  = SEG_W * SEGS;
  localparam int P_W   = 2 * OP_W;
  localparam int NPASS = SEGS * SEGS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_valid;
  logic              start_ready;
  logic [OP_W-1:0]   a_in;
  logic [OP_W-1:0]   b_in;
  logic              res_valid;
  logic              res_ready;
  logic [P_W-1:0]    product;
  logic              busy;
  logic [SEG_W-1:0]  mul_a;
  logic [SEG_W-1:0]  mul_b;
  logic [2*SEG_W-1:0] mul_p;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wallace_mul_seq_ctrl #(
    .SEG_W(SEG_W),
    .SEGS (SEGS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .product    (product),
    .busy       (busy),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p)
  );

  wallace5x5 u_mul (
    .a(mul_a),
    .b(mul_b),
    .p(mul_p)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [P_W-1:0] ref_mul(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    return P_W'(a) * P_W'(b);
  endfunction

  function automatic logic [SEG_W-1:0] seg_of(input logic [OP_W-1:0] v, input int k);
    logic [OP_W-1:0] s;
    s = v >> (SEG_W * k);
    return s[SEG_W-1:0];
  endfunction

  // One full operation from IDLE: accept, NPASS passes, optional backpressure
  // (with an optional start pulse that must be ignored), then the result handshake.
  task automatic run_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                        input int hold, input bit pulse);
    logic [P_W-1:0] exp;
    exp = ref_mul(a, b);
    check("idle_start_ready", start_ready, 1);
    a_in        = a;
    b_in        = b;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    a_in        = ~a;
    b_in        = ~b;
    for (int k = 0; k < NPASS; k++) begin
      check("run_busy", busy, 1);
      check("run_res_valid", res_valid, 0);
      check("run_start_ready", start_ready, 0);
      check("run_mul_a", mul_a, seg_of(a, k % SEGS));
      check("run_mul_b", mul_b, seg_of(b, k / SEGS));
      step();
    end
    // Accept edge plus NPASS pass edges: res_valid is up after the 5th edge.
    check("latency_res_valid", res_valid, 1);
    check("done_product", product, exp);
    check("done_mul_a", mul_a, 0);
    check("done_start_ready", start_ready, 0);
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (pulse && h == 0) begin
        start_valid = 1'b1;
        a_in        = OP_W'($urandom);
        b_in        = OP_W'($urandom);
      end
      step();
      start_valid = 1'b0;
      check("hold_res_valid", res_valid, 1);
      check("hold_product", product, exp);
      check("hold_start_ready", start_ready, 0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("post_res_valid", res_valid, 0);
    check("post_busy", busy, 0);
    check("post_start_ready", start_ready, 1);
    check("post_product_held", product, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [OP_W-1:0] qa [3];
    logic [OP_W-1:0] qb [3];
    logic [P_W-1:0]  expq [$];
    int qi, nacc, nres, last_acc;
    bit acc_now;

    rst_n       = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    a_in        = '0;
    b_in        = '0;
    step();
    step();
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    rst_n = 1'b1;
    step();
    check("rst_start_ready", start_ready, 1);

    // Directed cases.
    run_op(10'h0A3, 10'h049, 0, 1'b0);
    run_op(10'h3FF, 10'h3FF, 1, 1'b0);
    run_op(10'h155, 10'h2AA, 0, 1'b0);
    run_op(10'h000, 10'h3FF, 0, 1'b0);
    run_op(10'h3FF, 10'h001, 3, 1'b1);

    // Reset after two RUN cycles must clear everything at once.
    a_in        = 10'h3FF;
    b_in        = 10'h3FF;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("abort_res_valid", res_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_product", product, 0);
    check("abort_mul_a", mul_a, 0);
    check("abort_mul_b", mul_b, 0);
    step();
    rst_n = 1'b1;
    step();
    run_op(10'h021, 10'h043, 0, 1'b0);

    // Back-to-back with start_valid held high and res_ready held high.
    qa[0] = 10'h0A3; qb[0] = 10'h049;
    qa[1] = OP_W'($urandom); qb[1] = OP_W'($urandom);
    qa[2] = 10'h3FF; qb[2] = 10'h2AA;
    qi = 0; nacc = 0; nres = 0; last_acc = 0;
    a_in        = qa[0];
    b_in        = qb[0];
    start_valid = 1'b1;
    res_ready   = 1'b1;
    for (int cyc = 0; cyc < 60 && nres < 3; cyc++) begin
      if (res_valid) begin
        if (expq.size() > 0) check("b2b_product", product, expq.pop_front());
        else check("b2b_unexpected_result", 1, 0);
        nres++;
      end
      acc_now = start_valid && start_ready;
      if (acc_now) begin
        if (nacc > 0) check("b2b_interval", cyc - last_acc, NPASS + 2);
        last_acc = cyc;
        expq.push_back(ref_mul(qa[qi], qb[qi]));
        nacc++;
      end
      step();
      if (acc_now) begin
        qi++;
        if (qi < 3) begin
          a_in = qa[qi];
          b_in = qb[qi];
        end else begin
          start_valid = 1'b0;
        end
      end
    end
    res_ready   = 1'b0;
    start_valid = 1'b0;
    check("b2b_results", nres, 3);
    check("b2b_accepts", nacc, 3);
    check("b2b_idle", busy, 0);

    // Randomized operands with random backpressure and stray start pulses.
    for (int t = 0; t < 24; t++) begin
      run_op(OP_W'($urandom), OP_W'($urandom), int'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
